// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared CPU package: function-code type and the HI/LO
//                related function codes used by the ALU and the multiply /
//                divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // Function field of an R-type instruction. Kept as a plain vector so that
    // unsupported codes can still be presented to the units.
    typedef logic [5:0] funct_t;

    localparam funct_t FUNCT_MFHI  = 6'h10;
    localparam funct_t FUNCT_MTHI  = 6'h11;
    localparam funct_t FUNCT_MFLO  = 6'h12;
    localparam funct_t FUNCT_MTLO  = 6'h13;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1A;
    localparam funct_t FUNCT_DIVU  = 6'h1B;

    // True for the codes that start a multi-cycle multiply or divide.
    function automatic logic is_muldiv(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Request / result bundle between the pipeline (master) and
//                the multiply / divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    import mult_div_unit_pkg::*;

    logic             start;
    funct_t           fncode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, fncode, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, fncode, a, b,
        output busy, done, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative HI/LO multiply / divide unit. Shift-add multiply
//                and restoring divide, one bit per cycle on operand
//                magnitudes, with sign correction in a final FIX cycle.
//                MTHI/MTLO write HI/LO directly in a single cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mult_div_unit_if.slave      bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_busy;

    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_main;   // negate product / quotient
    logic             r_neg_rem;    // negate remainder (dividend negative)
    logic             r_div0;       // divisor was zero
    logic [WIDTH-1:0] r_mcand;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_acc;        // product upper half or partial remainder
    logic [WIDTH-1:0] r_shift;      // multiplier / product lower half or quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic             w_idle;
    logic             w_accept;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_div_op;
    logic             w_signed_op;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_last;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = bus.start && w_idle && is_muldiv(bus.fncode);
    assign w_mthi      = bus.start && w_idle && (bus.fncode == FUNCT_MTHI);
    assign w_mtlo      = bus.start && w_idle && (bus.fncode == FUNCT_MTLO);
    assign w_div_op    = (bus.fncode == FUNCT_DIV) || (bus.fncode == FUNCT_DIVU);
    assign w_signed_op = (bus.fncode == FUNCT_MULT) || (bus.fncode == FUNCT_DIV);
    assign w_sa        = w_signed_op && bus.a[WIDTH-1];
    assign w_sb        = w_signed_op && bus.b[WIDTH-1];
    assign w_mag_a     = w_sa ? -bus.a : bus.a;
    assign w_mag_b     = w_sb ? -bus.b : bus.b;
    assign w_last      = (r_count == CW'(WIDTH - 1));

    // ------------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------------
    logic [WIDTH:0]     w_add;      // multiply: acc + (bit ? mcand : 0)
    logic [WIDTH:0]     w_trial;    // divide: remainder shifted in next bit
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;

    assign w_add   = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_trial = {r_acc, r_shift[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_mcand};
    assign w_qbit  = ~w_diff[WIDTH];

    // ------------------------------------------------------------------------
    // Sign correction applied in FIX
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod     = {r_acc, r_shift};
    assign w_prod_fix = r_neg_main ? -w_prod : w_prod;
    // Divide by zero reports an all-ones quotient regardless of signs; the
    // remainder is |a| re-signed by the dividend, which reproduces a.
    assign w_quot_fix = r_div0 ? {WIDTH{1'b1}} : (r_neg_main ? -r_shift : r_shift);
    assign w_rem_fix  = r_neg_rem ? -r_acc : r_acc;
    assign w_res_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and busy decode.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Operand capture at acceptance, then one multiply / divide bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
        end else if (w_accept) begin
            r_count    <= '0;
            r_is_div   <= w_div_op;
            r_neg_main <= w_sa ^ w_sb;
            r_neg_rem  <= w_sa;
            r_div0     <= w_div_op && (bus.b == '0);
            r_acc      <= '0;
            r_mcand    <= w_div_op ? w_mag_b : w_mag_a;
            r_shift    <= w_div_op ? w_mag_a : w_mag_b;
        end else if (r_state == ST_RUN) begin
            r_count <= r_count + 1'b1;
            if (r_is_div) begin
                r_acc   <= w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_shift <= {r_shift[WIDTH-2:0], w_qbit};
            end else begin
                r_acc   <= w_add[WIDTH:1];
                r_shift <= {w_add[0], r_shift[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: result write on leaving FIX, direct writes from MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_mthi) begin
            r_hi <= bus.a;
        end else if (w_mtlo) begin
            r_lo <= bus.a;
        end
    end

    // Completion pulse in the first IDLE cycle after FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= (r_state == ST_FIX);
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and HI/LO width (even, >=4).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request; sampled at a rising edge.
REQ-006 Port: fncode  input  funct_t  operation select, sampled with start.
REQ-007 Port: a  input  WIDTH  operand rs (dividend / multiplicand / MTHI-MTLO data).
REQ-008 Port: b  input  WIDTH  operand rt (divisor / multiplier).
REQ-009 Port: busy  output  1  high while a multiply/divide is in flight.
REQ-010 Port: done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-011 Port: hi  output  WIDTH  HI register (MFHI source), registered.
REQ-012 Port: lo  output  WIDTH  LO register (MFLO source), registered.

Function
REQ-013 Supported fncode values: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO; others with start SHALL be ignored.
REQ-014 FSM states IDLE, RUN, FIX; IDLE->RUN on accepted MULT/MULTU/DIV/DIVU; RUN->FIX after exactly WIDTH iterations; FIX->IDLE unconditionally.
REQ-015 start SHALL be accepted only when state is IDLE; start while busy SHALL be ignored with no effect on the in-flight operation or HI/LO.
REQ-016 busy SHALL be high in RUN and FIX, low in IDLE.
REQ-017 done SHALL be high for exactly the one cycle after FIX (state IDLE), WIDTH+2 cycles after the accepting edge; a new start in that cycle SHALL be accepted.
REQ-018 HI/LO SHALL update only at the FIX->IDLE edge for mult/div; they SHALL hold their old value throughout RUN and FIX.
REQ-019 Multiply: iterative shift-add, one multiplier bit per cycle, on operand magnitudes; {hi,lo} = full 2*WIDTH-bit product.
REQ-020 MULT SHALL treat a,b as two's complement and negate the 2*WIDTH product in FIX when signs differ; MULTU SHALL treat them as unsigned.
REQ-021 Divide: restoring, one quotient bit per cycle, on magnitudes; lo = quotient, hi = remainder.
REQ-022 DIV: quotient negated when operand signs differ, remainder takes sign of dividend (truncation toward zero).
REQ-023 DIV of most-negative by -1 SHALL give lo = most-negative, hi = 0 (no exception).
REQ-024 Divide by zero (DIV or DIVU) SHALL give lo = all ones, hi = a, with normal latency and done pulse.
REQ-025 Operands a, b, fncode SHALL be captured at acceptance; later input changes SHALL not affect the result.
REQ-026 MTHI/MTLO accepted in IDLE SHALL write a to hi/lo at that edge, single cycle, busy stays low, no done pulse.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, iteration counter 0, operand registers 0.
REQ-028 Reset mid-operation SHALL abandon the operation; no done pulse after reset release; first start after release SHALL be accepted normally.

Structure
REQ-029 funct_t and the FUNCT_* constants (including MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) SHALL live in the shared CPU package used by alu; the FSM state type is local.
REQ-030 Datapath SHALL be a single module; no sub-module required; iteration counter width $clog2(WIDTH+1).

Verification (WIDTH=32)
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at 34th cycle after accept, hi=0xFFFFFFFE lo=0x00000001.
REQ-032 MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; DIVU 7/2 -> lo=3 hi=1.
REQ-033 DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-034 DIVU 5/0 -> lo=0xFFFFFFFF hi=5; then MTHI 0x1234 -> hi=0x1234 next edge, no done, lo unchanged.
REQ-035 DIVU 100/7 with start and a new MULTU pulsed mid-RUN and operands changed -> lo=14 hi=2, single done, second request ignored.
REQ-036 rst_n low at cycle 10 of a MULT -> hi=lo=0, busy=0 immediately; no done after release; following MULTU 3*4 -> lo=12 hi=0.
